mem_port_arbiter: RTL and testbench

Two-requester arbiter and handshake sequencer for the single-port 512-byte RAM of the multicycle MIPS core. It shares the RAM between the instruction-fetch path and the load/store data path, grants them round-robin, and drives the RAM's MOV/MemRead/MemWrite strobes. It completes a four-phase MOV/MOC handshake and returns read data to the granted requester with a one-cycle acknowledge. The block sits between the control unit/MAR/MDR and the RAM.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr.sv | 25 ++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// No logic; widths, state encoding and grant IDs only.
// Optional handshake watchdog is enabled by MEM_ARB_TIMEOUT_EN in the top.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker between fetch and data requests.
// Combinational, zero latency.
// No backpressure; the parent decides when the pick is consumed.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic last_grant_i,
  output logic gnt_vld_o,
  output logic gnt_id_o
);

  // Lone request wins; on a tie the side not served last wins.
  always_comb begin
    gnt_vld_o = if_req_i | d_req_i;
    gnt_id_o  = GRANT_IF;
    if (if_req_i && d_req_i) begin
      gnt_id_o = (last_grant_i == GRANT_D) ? GRANT_IF : GRANT_D;
    end else if (d_req_i) begin
      gnt_id_o = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port RAM between fetch and load/store with a MOV/MOC four-phase handshake.
// Latency 4 cycles request-to-ack with an immediate RAM; each extra MOC wait cycle adds one.
// Requesters hold req until their one-cycle ack; MEM_ARB_TIMEOUT_EN adds a handshake watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_mov,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_moc,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  state_t            state_q;
  logic              last_grant_q;
  logic              gnt_q;
  logic              we_q;
  logic              mov_q, rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf_q;
  logic              if_ack_q, d_ack_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              gnt_vld, gnt_id;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             to_hit;
  logic             err_q;
  assign to_cnt_d = to_cnt_q + CNT_W'(1);
  assign to_hit   = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err      = err_q;
`else
  // Watchdog limit has no effect in this build; err is fixed low.
  assign err = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

  mem_arb_rr u_rr (
    .if_req_i     (if_req),
    .d_req_i      (d_req),
    .last_grant_i (last_grant_q),
    .gnt_vld_o    (gnt_vld),
    .gnt_id_o     (gnt_id)
  );

  // Handshake sequencer; the ack cycle itself is never a grant cycle, so a
  // requester still holding req while it sees ack is not re-granted early.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      gnt_q        <= GRANT_IF;
      we_q         <= 1'b0;
      mov_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (gnt_vld && !if_ack_q && !d_ack_q) begin
            state_q      <= SETUP;
            gnt_q        <= gnt_id;
            last_grant_q <= gnt_id;
            if (gnt_id == GRANT_IF) begin
              addr_q <= if_addr;
              we_q   <= 1'b0;
              rd_q   <= 1'b1;
              wr_q   <= 1'b0;
            end else begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              we_q    <= d_we;
              rd_q    <= ~d_we;
              wr_q    <= d_we;
            end
          end
        end
        SETUP: begin
          state_q <= STROBE;
          mov_q   <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        STROBE: begin
          if (mem_moc) begin
            state_q <= RELEASE;
            rbuf_q  <= mem_rdata;
            mov_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
          end else if (to_hit) begin
            state_q <= IDLE;
            mov_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b1;
            if (gnt_q == GRANT_IF) if_ack_q <= 1'b1;
            else                   d_ack_q  <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_d;
`endif
          end
        end
        RELEASE: begin
          if (!mem_moc) begin
            state_q <= IDLE;
            if (gnt_q == GRANT_IF) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= rbuf_q;
            end else begin
              d_ack_q <= 1'b1;
              if (!we_q) d_rdata_q <= rbuf_q;
            end
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (to_hit) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            if (gnt_q == GRANT_IF) if_ack_q <= 1'b1;
            else                   d_ack_q  <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_mov   = mov_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural RAM and transaction model.
// Expected ack cycles derive from 4 + MOC wait cycles; ties resolve against the last winner.
// With MEM_ARB_TIMEOUT_EN the DUT watchdog is shortened to 8 cycles and a dead RAM is tested.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TB_TO = 8;
`else
  localparam int TB_TO = 255;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [8:0]  if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        if_ack, d_ack, mem_mov, mem_read, mem_write, mem_moc, busy, err;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [8:0]  mem_addr;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_mov(mem_mov), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_moc(mem_moc),
    .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // RAM model: MOC rises moc_delay cycles after MOV, holds while MOV is high,
  // then lingers moc_hold cycles after MOV falls.
  logic [31:0] ram     [0:127];
  logic [31:0] ref_mem [0:127];
  int mov_cnt = 0, rel_cnt = 0, moc_delay = 0, moc_hold = 0;
  bit rel_act = 1'b0, moc_dead = 1'b0;

  assign mem_moc   = !moc_dead && ((mem_mov && (mov_cnt >= moc_delay)) ||
                                   (rel_act && (rel_cnt < moc_hold)));
  assign mem_rdata = ram[mem_addr[8:2]];

  always @(posedge clock) begin
    if (mem_mov) mov_cnt <= mov_cnt + 1;
    else         mov_cnt <= 0;
    if (mem_mov && mem_moc) begin
      rel_act <= 1'b1;
      rel_cnt <= 0;
      if (mem_write) ram[mem_addr[8:2]] <= mem_wdata;
    end else if (rel_act && !mem_mov) begin
      if (rel_cnt + 1 >= moc_hold) rel_act <= 1'b0;
      rel_cnt <= rel_cnt + 1;
    end
  end

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Results of the last run() call.
  int r_if, r_d, r_mvf, r_mvn, r_rdf, r_rdn, r_wrn, r_both;
  logic [31:0] r_wd, r_ifd, r_dd;
  logic r_err, r_mvack;

  // Presents requests in the current (idle) cycle, which is cycle 0; drops
  // each req in its ack cycle; then spends one quiet idle cycle.
  task automatic run(input bit rq_if, input bit rq_d, input bit we,
                     input logic [8:0] ia, input logic [8:0] da, input logic [31:0] wd,
                     input int dly, input int hold);
    moc_delay = dly; moc_hold = hold;
    if_addr = ia; d_addr = da; d_we = we; d_wdata = wd;
    if_req = rq_if; d_req = rq_d;
    r_if = -1; r_d = -1; r_mvf = -1; r_mvn = 0; r_rdf = -1; r_rdn = 0; r_wrn = 0;
    r_both = 0; r_wd = '0; r_err = 1'b0; r_mvack = 1'b0;
    r_ifd = if_rdata; r_dd = d_rdata;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock); #1;
      if (r_if < 0 && r_d < 0) begin
        if (mem_mov)   begin if (r_mvf < 0) r_mvf = k; r_mvn++; end
        if (mem_read)  begin if (r_rdf < 0) r_rdf = k; r_rdn++; end
        if (mem_write) begin r_wrn++; r_wd = mem_wdata; end
      end
      if (if_ack && d_ack) r_both++;
      if (if_ack || d_ack) begin r_err = r_err | err; r_mvack = r_mvack | mem_mov; end
      if (if_ack) begin if (r_if < 0) begin r_if = k; r_ifd = if_rdata; end if_req = 1'b0; end
      if (d_ack)  begin if (r_d  < 0) begin r_d  = k; r_dd  = d_rdata;  end d_req  = 1'b0; end
      if (!if_req && !d_req) break;
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clock); #1;
    chk("quiet_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("quiet_busy", {31'd0, busy}, 32'd0);
  endtask

  bit lg_m;                       // 0 = fetch served last, 1 = data served last
  logic [31:0] exp_ifd, exp_dd;

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram[i] = $urandom; ref_mem[i] = ram[i];
    end
    ram[0] = 32'h2401002C; ref_mem[0] = 32'h2401002C;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_strobes", {29'd0, mem_mov, mem_read, mem_write}, 32'd0);
    chk("rst_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_misc", {28'd0, if_ack, d_ack, busy, err}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    lg_m = 1'b1; exp_ifd = '0; exp_dd = '0;

    // Tie after reset with both requests held: fetch first, then strict alternation
    begin
      int n = 0;
      if_addr = 9'h000; d_addr = 9'h008; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
      for (int k = 1; k <= 100 && n < 4; k++) begin
        @(posedge clock); #1;
        if (if_ack || d_ack) begin
          chk("alt_one_ack", {31'd0, if_ack & d_ack}, 32'd0);
          chk("alt_who", {31'd0, d_ack}, 32'(n % 2));
          chk("alt_cyc", k, 4 + 5 * n);
          if (if_ack) chk("alt_ifd", if_rdata, ref_mem[0]);
          else        chk("alt_dd", d_rdata, ref_mem[2]);
          n++;
          if (n == 4) begin if_req = 1'b0; d_req = 1'b0; end
        end
      end
      chk("alt_count", n, 4);
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clock); #1;
      chk("alt_quiet", {30'd0, if_ack, d_ack}, 32'd0);
      lg_m = 1'b1; exp_ifd = ref_mem[0]; exp_dd = ref_mem[2];
    end

    // Fetch, immediate MOC
    run(1, 0, 0, 9'h000, 9'h000, 32'h0, 0, 0);
    chk("fetch_ack_cyc", r_if, 4);
    chk("fetch_no_dack", r_d, -1);
    chk("fetch_rd_first", r_rdf, 1);
    chk("fetch_rd_n", r_rdn, 2);
    chk("fetch_mov_first", r_mvf, 2);
    chk("fetch_mov_n", r_mvn, 1);
    chk("fetch_rdata", r_ifd, 32'h2401002C);
    lg_m = 1'b0;

    // Store
    run(0, 1, 1, 9'h000, 9'h004, 32'hA0250001, 0, 0);
    chk("store_ack_cyc", r_d, 4);
    chk("store_no_ifack", r_if, -1);
    chk("store_wr_n", r_wrn, 2);
    chk("store_rd_n", r_rdn, 0);
    chk("store_wdata", r_wd, 32'hA0250001);
    chk("store_drdata", r_dd, exp_dd);
    chk("store_ifrdata", r_ifd, exp_ifd);
    ref_mem[1] = 32'hA0250001; lg_m = 1'b1;

    // Load back the stored word
    run(0, 1, 0, 9'h000, 9'h004, 32'h0, 0, 0);
    chk("load_ack_cyc", r_d, 4);
    chk("load_rdata", r_dd, 32'hA0250001);
    exp_dd = 32'hA0250001;

`ifndef MEM_ARB_TIMEOUT_EN
    // Slow RAM: MOC 10 cycles after MOV
    run(1, 0, 0, 9'h000, 9'h000, 32'h0, 10, 0);
    chk("slow_mov_first", r_mvf, 2);
    chk("slow_mov_n", r_mvn, 11);
    chk("slow_ack_cyc", r_if, 14);
    lg_m = 1'b0;
`endif

    // Reset during STROBE
    moc_delay = 0; moc_hold = 0;
    if_addr = 9'h000; if_req = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("mid_mov_before", {31'd0, mem_mov}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_drop", {29'd0, mem_mov, mem_read, busy}, 32'd0);
    chk("mid_rst_ack", {30'd0, if_ack, d_ack}, 32'd0);
    if_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk("mid_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
    end
    lg_m = 1'b1; exp_ifd = '0; exp_dd = '0;
    run(1, 0, 0, 9'h000, 9'h000, 32'h0, 0, 0);
    chk("post_rst_ack_cyc", r_if, 4);
    chk("post_rst_rdata", r_ifd, 32'h2401002C);
    lg_m = 1'b0; exp_ifd = 32'h2401002C;

    // Randomized transactions against the reference model
    for (int it = 0; it < 30; it++) begin
      int sel, dly, hold, lat, e_if, e_d, n_w;
      bit rq_if, rq_d, we, w0;
      logic [8:0] ia, da;
      logic [31:0] wd;
      sel = $urandom_range(1, 3);
      rq_if = sel[0]; rq_d = sel[1];
      we = 1'($urandom_range(0, 1));
      ia = {7'($urandom), 2'b00};
      da = {7'($urandom), 2'b00};
      wd = $urandom;
      dly = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      lat = 4 + dly + hold;
      if (rq_if && rq_d) begin w0 = ~lg_m; n_w = 2; end
      else begin w0 = rq_d; n_w = 1; end
      e_if = -1; e_d = -1;
      for (int j = 0; j < n_w; j++) begin
        bit who;
        int cyc;
        who = (j == 0) ? w0 : ~w0;
        cyc = lat + j * (lat + 1);
        if (!who) begin
          e_if = cyc; exp_ifd = ref_mem[ia[8:2]];
        end else begin
          e_d = cyc;
          if (we) ref_mem[da[8:2]] = wd;
          else    exp_dd = ref_mem[da[8:2]];
        end
        lg_m = who;
      end
      run(rq_if, rq_d, we, ia, da, wd, dly, hold);
      chk("rnd_if_cyc", r_if, e_if);
      chk("rnd_d_cyc", r_d, e_d);
      chk("rnd_ifd", r_ifd, exp_ifd);
      chk("rnd_dd", r_dd, exp_dd);
      chk("rnd_both", r_both, 0);
      chk("rnd_err", {31'd0, r_err}, 32'd0);
      chk("rnd_mov_at_ack", {31'd0, r_mvack}, 32'd0);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Dead RAM: watchdog completes the load with err
    moc_dead = 1'b1;
    run(0, 1, 0, 9'h000, 9'h010, 32'h0, 0, 0);
    chk("to_ack_cyc", r_d, 10);
    chk("to_err", {31'd0, r_err}, 32'd1);
    chk("to_mov_at_ack", {31'd0, r_mvack}, 32'd0);
    chk("to_mov_n", r_mvn, 8);
    chk("to_drdata", r_dd, exp_dd);
    moc_dead = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
